oled_spi_responder: RTL and testbench



---
 rtl/oled_spi_responder.sv | 211 +++++++++++++++++++++
 tb/tb_oled_spi_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_responder.sv
// SSD1306-style SPI display responder: deserialises the SPI stream, decodes the addressing command subset,
// and writes data bytes into a page/column framebuffer that has a registered, read-first read port.
module oled_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8,
  localparam int CW         = $clog2(COLS),
  localparam int PW         = $clog2(PAGES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_clk,
  input  logic          mosi,
  input  logic          dc,
  input  logic          cs_n,
  input  logic [PW-1:0] rd_page,
  input  logic [CW-1:0] rd_col,
  output logic [7:0]    rd_data,
  output logic          byte_valid,
  output logic [7:0]    byte_data,
  output logic          byte_dc,
  output logic          display_on,
  output logic [PW-1:0] cur_page,
  output logic [CW-1:0] cur_col
);

  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

  typedef enum logic [2:0] {IDLE, ARG1, COLSTART, COLEND, PAGESTART, PAGEEND, MODE} state_t;

  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, dc_q, csn_q, done_pipe;
  logic                   sclk_d, sclk_rise, sel, done_now, rx_dc;
  logic [2:0]             bit_cnt;
  logic [6:0]             shreg;
  logic [7:0]             rx_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      mosi_q <= '0;
      dc_q   <= '0;
      csn_q  <= '1;
      sclk_d <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      dc_q   <= {dc_q[SYNC_STAGES-2:0], dc};
      csn_q  <= {csn_q[SYNC_STAGES-2:0], cs_n};
      sclk_d <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sel       = ~csn_q[SYNC_STAGES-1];
  assign done_now  = sclk_rise & sel & (bit_cnt == 3'd7);

  // The completion pulse is delayed so byte_valid lands SYNC_STAGES+1 cycles after the detected edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      rx_dc      <= 1'b0;
      done_pipe  <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      done_pipe  <= {done_pipe[SYNC_STAGES-2:0], done_now};
      byte_valid <= done_pipe[SYNC_STAGES-1];
      if (done_pipe[SYNC_STAGES-1]) begin
        byte_data <= rx_byte;
        byte_dc   <= rx_dc;
      end
      if (!sel) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shreg   <= {shreg[5:0], mosi_q[SYNC_STAGES-1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte <= {shreg, mosi_q[SYNC_STAGES-1]};
          rx_dc   <= dc_q[SYNC_STAGES-1];
        end
      end
    end
  end

  state_t        state, state_nx;
  logic [1:0]    mode, mode_nx;
  logic [CW-1:0] col_start, col_end, col_start_nx, col_end_nx, col_nx, col_step;
  logic [PW-1:0] page_start, page_end, page_start_nx, page_end_nx, page_nx, page_step;
  logic          disp_nx, col_wrap, page_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode       <= 2'd2;
      col_start  <= '0;
      col_end    <= COL_LAST;
      page_start <= '0;
      page_end   <= PAGE_LAST;
      cur_col    <= '0;
      cur_page   <= '0;
      display_on <= 1'b0;
    end else begin
      state      <= state_nx;
      mode       <= mode_nx;
      col_start  <= col_start_nx;
      col_end    <= col_end_nx;
      page_start <= page_start_nx;
      page_end   <= page_end_nx;
      cur_col    <= col_nx;
      cur_page   <= page_nx;
      display_on <= disp_nx;
    end
  end

  // An inverted window (start > end) counts as "at the end" on every step.
  assign col_wrap  = (cur_col == col_end) || (col_start > col_end);
  assign col_step  = col_wrap ? col_start : cur_col + 1'b1;
  assign page_wrap = (cur_page == page_end) || (page_start > page_end);
  assign page_step = page_wrap ? page_start : cur_page + 1'b1;

  always_comb begin
    state_nx      = state;
    mode_nx       = mode;
    col_start_nx  = col_start;
    col_end_nx    = col_end;
    page_start_nx = page_start;
    page_end_nx   = page_end;
    col_nx        = cur_col;
    page_nx       = cur_page;
    disp_nx       = display_on;
    if (byte_valid) begin
      if (byte_dc) begin
        state_nx = IDLE;
        case (mode)
          2'd0: begin
            col_nx = col_step;
            if (col_wrap) page_nx = page_step;
          end
          2'd1: begin
            page_nx = page_step;
            if (page_wrap) col_nx = col_step;
          end
          default: col_nx = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (byte_data[7:4] == 4'h0) begin
              col_nx[3:0] = byte_data[3:0];
            end else if (byte_data[7:3] == 5'b00010) begin
              col_nx[CW-1:4] = byte_data[CW-5:0];
            end else if (byte_data[7:3] == 5'b10110) begin
              page_nx = byte_data[PW-1:0];
            end else begin
              case (byte_data)
                8'h20: state_nx = MODE;
                8'h21: state_nx = COLSTART;
                8'h22: state_nx = PAGESTART;
                8'hAE: disp_nx = 1'b0;
                8'hAF: disp_nx = 1'b1;
                8'h81, 8'h8D, 8'hA8, 8'hD3,
                8'hD5, 8'hD9, 8'hDA, 8'hDB: state_nx = ARG1;
                default: ;
              endcase
            end
          end
          COLSTART: begin
            col_start_nx = byte_data[CW-1:0];
            col_nx       = byte_data[CW-1:0];
            state_nx     = COLEND;
          end
          COLEND: begin
            col_end_nx = byte_data[CW-1:0];
            state_nx   = IDLE;
          end
          PAGESTART: begin
            page_start_nx = byte_data[PW-1:0];
            page_nx       = byte_data[PW-1:0];
            state_nx      = PAGEEND;
          end
          PAGEEND: begin
            page_end_nx = byte_data[PW-1:0];
            state_nx    = IDLE;
          end
          MODE: begin
            mode_nx  = (byte_data[1:0] == 2'd3) ? 2'd2 : byte_data[1:0];
            state_nx = IDLE;
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // Framebuffer deliberately has no reset so its contents survive rst_n.
  logic [7:0] fb [0:(1<<(PW+CW))-1];

  always_ff @(posedge clk) begin
    if (byte_valid && byte_dc) fb[{cur_page, cur_col}] <= byte_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= fb[{rd_page, rd_col}];
  end

endmodule

// File: tb/tb_oled_spi_responder.sv
// Bench for oled_spi_responder: directed vector table, corner sequences, then random bytes against a model.
module tb_oled_spi_responder;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;

  logic       clk, rst_n, spi_clk, mosi, dc, cs_n;
  logic [2:0] rd_page, cur_page;
  logic [6:0] rd_col, cur_col;
  logic [7:0] rd_data, byte_data;
  logic       byte_valid, byte_dc, display_on;

  oled_spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .mosi(mosi), .dc(dc), .cs_n(cs_n),
    .rd_page(rd_page), .rd_col(rd_col), .rd_data(rd_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .display_on(display_on), .cur_page(cur_page), .cur_col(cur_col)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, rise_cyc = 0;
  int bv_cnt = 0, bv_cyc = 0, bv_dat = 0, bv_dc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt = bv_cnt + 1;
      bv_cyc = cyc;
      bv_dat = byte_data;
      bv_dc  = byte_dc;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: what the display would hold, straight from the command rules.
  logic [7:0] fbm   [8][128];
  bit         known [8][128];
  int m_col, m_page, m_mode, m_cs, m_ce, m_ps, m_pe, m_disp;
  int pend[$];   // argument roles still owed: 1 ignore, 2 col start, 3 col end, 4 page start, 5 page end, 6 mode

  task automatic model_reset();
    m_col = 0; m_page = 0; m_mode = 2; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_disp = 0;
    pend.delete();
  endtask

  function automatic int win_step(input int v, input int s, input int e, input int n, output bit wrapped);
    wrapped = 1'b1;
    if (s > e || v == e) return s;
    wrapped = 1'b0;
    return (v + 1) % n;
  endfunction

  task automatic model_byte(input bit d, input int b);
    bit w;
    int role;
    if (d) begin
      pend.delete();
      fbm[m_page][m_col] = b[7:0];
      known[m_page][m_col] = 1'b1;
      if (m_mode == 0) begin
        m_col = win_step(m_col, m_cs, m_ce, 128, w);
        if (w) m_page = win_step(m_page, m_ps, m_pe, 8, w);
      end else if (m_mode == 1) begin
        m_page = win_step(m_page, m_ps, m_pe, 8, w);
        if (w) m_col = win_step(m_col, m_cs, m_ce, 128, w);
      end else begin
        m_col = (m_col + 1) % 128;
      end
    end else if (pend.size() > 0) begin
      role = pend.pop_front();
      case (role)
        2: begin m_cs = b % 128; m_col = m_cs; end
        3: m_ce = b % 128;
        4: begin m_ps = b % 8; m_page = m_ps; end
        5: m_pe = b % 8;
        6: m_mode = (b % 4 == 3) ? 2 : b % 4;
        default: ;
      endcase
    end else if (b <= 'h0F) m_col = (m_col / 16) * 16 + b;
    else if (b >= 'h10 && b <= 'h17) m_col = (m_col % 16) + (b - 'h10) * 16;
    else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
    else if (b == 'h20) pend.push_back(6);
    else if (b == 'h21) begin pend.push_back(2); pend.push_back(3); end
    else if (b == 'h22) begin pend.push_back(4); pend.push_back(5); end
    else if (b == 'hAE) m_disp = 0;
    else if (b == 'hAF) m_disp = 1;
    else if (b == 'h81 || b == 'h8D || b == 'hA8 || b == 'hD3 ||
             b == 'hD5 || b == 'hD9 || b == 'hDA || b == 'hDB) pend.push_back(1);
  endtask

  task automatic spi_bits(input logic [7:0] b, input logic d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      cs_n = 1'b0; dc = d; mosi = b[7-i];
      wait_clk(HALF);
      spi_clk = 1'b1; rise_cyc = cyc;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input bit d, input int b);
    spi_bits(b[7:0], d, 8);
    wait_clk(6);
    model_byte(d, b);
  endtask

  task automatic read_fb(input int p, input int c, output int v);
    rd_page = p[2:0]; rd_col = c[6:0];
    wait_clk(1);
    v = rd_data;
  endtask

  typedef struct {
    bit kind;   // 0: send a byte, 1: read framebuffer
    bit d;
    int dat;    // byte sent, or expected rd_data
    int page;   // expected cur_page, or read page
    int col;    // expected cur_col, or read column
    int disp;
  } vec_t;
  vec_t vec[$];

  task automatic add_b(input bit d, input int dat, input int p, input int c, input int disp);
    vec_t v;
    v.kind = 1'b0; v.d = d; v.dat = dat; v.page = p; v.col = c; v.disp = disp;
    vec.push_back(v);
  endtask
  task automatic add_r(input int p, input int c, input int exp);
    vec_t v;
    v.kind = 1'b1; v.d = 1'b0; v.dat = exp; v.page = p; v.col = c; v.disp = 0;
    vec.push_back(v);
  endtask

  initial begin
    int c0, v, b;
    bit d;
    spi_clk = 0; mosi = 0; dc = 0; cs_n = 1; rst_n = 0; rd_page = 0; rd_col = 0;
    model_reset();

    add_b(0,'hAF,0,0,1);    add_b(0,'hB3,3,0,1);    add_b(0,'h05,3,5,1);    add_b(0,'h12,3,'h25,1);
    add_b(1,'hA5,3,'h26,1);
    add_b(0,'h20,3,'h26,1); add_b(0,'h00,3,'h26,1);
    add_b(0,'h21,3,'h26,1); add_b(0,'h7E,3,'h7E,1); add_b(0,'h7F,3,'h7E,1);
    add_b(0,'h22,3,'h7E,1); add_b(0,'h06,6,'h7E,1); add_b(0,'h07,6,'h7E,1);
    add_b(1,'h11,6,'h7F,1); add_b(1,'h22,7,'h7E,1); add_b(1,'h33,7,'h7F,1);
    add_b(1,'h44,6,'h7E,1); add_b(1,'h55,6,'h7F,1);
    add_r(3,'h25,'hA5); add_r(6,'h7E,'h55); add_r(6,'h7F,'h22); add_r(7,'h7E,'h33); add_r(7,'h7F,'h44);
    add_b(0,'h20,6,'h7F,1); add_b(0,'h02,6,'h7F,1);
    add_b(0,'hB0,0,'h7F,1); add_b(0,'h0F,0,'h7F,1); add_b(0,'h17,0,'h7F,1);
    add_b(1,'hFF,0,0,1);    add_r(0,'h7F,'hFF);
    add_b(0,'h81,0,0,1);    add_b(1,'h3C,0,1,1);    add_b(0,'hB5,5,1,1);    add_r(0,0,'h3C);
    add_b(0,'hAE,5,1,0);    add_b(0,'hE3,5,1,0);    add_b(0,'hAF,5,1,1);
    add_b(0,'h20,5,1,1);    add_b(0,'h01,5,1,1);
    add_b(0,'hB6,6,1,1);    add_b(0,'h0E,6,'h0E,1); add_b(0,'h17,6,'h7E,1);
    add_b(1,'h01,7,'h7E,1); add_b(1,'h02,6,'h7F,1);
    add_r(6,'h7E,'h01);     add_r(7,'h7E,'h02);

    wait_clk(3);
    check("rst_rd_data", rd_data, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_byte_dc", byte_dc, 0);
    check("rst_display_on", display_on, 0);
    check("rst_cur_page", cur_page, 0);
    check("rst_cur_col", cur_col, 0);
    rst_n = 1;
    wait_clk(3);

    foreach (vec[i]) begin
      if (vec[i].kind == 1'b0) begin
        c0 = bv_cnt;
        send_byte(vec[i].d, vec[i].dat);
        check($sformatf("v%0d_pulses", i), bv_cnt - c0, 1);
        check($sformatf("v%0d_byte_data", i), bv_dat, vec[i].dat);
        check($sformatf("v%0d_byte_dc", i), bv_dc, int'(vec[i].d));
        // synchroniser depth plus the SYNC_STAGES+1 cycles after the synchronised edge
        check($sformatf("v%0d_latency", i), bv_cyc - rise_cyc, 2 * SYNC_STAGES + 1);
        check($sformatf("v%0d_cur_page", i), cur_page, vec[i].page);
        check($sformatf("v%0d_cur_col", i), cur_col, vec[i].col);
        check($sformatf("v%0d_display_on", i), display_on, vec[i].disp);
      end else begin
        read_fb(vec[i].page, vec[i].col, v);
        check($sformatf("v%0d_rd_data", i), v, vec[i].dat);
      end
    end

    // Partial byte aborted by cs_n must vanish without a pulse.
    c0 = bv_cnt;
    spi_bits(8'hFF, 1'b0, 5);
    cs_n = 1'b1;
    wait_clk(12);
    check("partial_no_pulse", bv_cnt - c0, 0);
    send_byte(0, 'hB2);
    check("after_partial_pulses", bv_cnt - c0, 1);
    check("after_partial_byte", bv_dat, 'hB2);
    check("after_partial_page", cur_page, 2);
    check("after_partial_col", cur_col, m_col);

    // Reset in the middle of a data byte: no write, outputs back to reset values.
    c0 = bv_cnt;
    spi_bits(8'hEE, 1'b1, 5);
    rst_n = 1'b0;
    wait_clk(1);
    check("midrst_byte_valid", byte_valid, 0);
    check("midrst_byte_data", byte_data, 0);
    check("midrst_byte_dc", byte_dc, 0);
    check("midrst_display_on", display_on, 0);
    check("midrst_cur_page", cur_page, 0);
    check("midrst_cur_col", cur_col, 0);
    check("midrst_rd_data", rd_data, 0);
    cs_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    model_reset();
    wait_clk(12);
    check("midrst_no_pulse", bv_cnt - c0, 0);
    read_fb(0, 0, v);
    check("midrst_fb_kept", v, 'h3C);
    send_byte(0, 'hB1);
    check("midrst_next_page", cur_page, 1);

    for (int i = 0; i < 250; i++) begin
      d = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 5))
        0: b = $urandom_range(0, 255);
        1: b = $urandom_range(0, 'h17);
        2: b = 'hB0 + $urandom_range(0, 7);
        3: b = 'h20 + $urandom_range(0, 2);
        4: b = ($urandom_range(0, 1) == 1) ? 'hAE + $urandom_range(0, 1) : 'h81;
        default: b = $urandom_range(0, 3);
      endcase
      send_byte(d, b);
      check($sformatf("rnd%0d_cur_page", i), cur_page, m_page);
      check($sformatf("rnd%0d_cur_col", i), cur_col, m_col);
      check($sformatf("rnd%0d_display_on", i), display_on, m_disp);
    end
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 128; c++)
        if (known[p][c]) begin
          read_fb(p, c, v);
          check($sformatf("fb[%0d][%0d]", p, c), v, int'(fbm[p][c]));
        end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
